// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded hold time.
// Drives one-hot grant, owner select and the shared data mux output.
module bus_arbiter #(
   parameter int N        = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N*DATA_W-1:0]   data_in,
   output logic [N-1:0]          gnt,
   output logic [$clog2(N)-1:0]  sel,
   output logic                  valid,
   output logic [DATA_W-1:0]     bus_out
);

   localparam int SEL_W = $clog2(N);
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] hold_q, hold_d;

   logic [SEL_W-1:0] win;
   logic             found;
   logic             owner_req;
   logic             others;
   logic             take;

   // Scan from last+1 with wrap; the current owner is reached last.
   always_comb begin
      win   = last_q;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[(int'(last_q) + k) % N]) begin
            found = 1'b1;
            win   = SEL_W'((int'(last_q) + k) % N);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      last_d    = last_q;
      hold_d    = hold_q;
      take      = 1'b0;
      owner_req = |(req & gnt_q);
      others    = |(req & ~gnt_q);
      unique case (state_q)
         IDLE: begin
            take = found;
         end
         GRANT: begin
            if (!owner_req) begin
               if (others) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (hold_q == HOLD_MAX && others) begin
               take = 1'b1;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
      if (take) begin
         state_d    = GRANT;
         gnt_d      = '0;
         gnt_d[win] = 1'b1;
         sel_d      = win;
         last_d     = win;
         hold_d     = CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign valid   = |gnt_q;
   assign bus_out = valid ? data_in[int'(sel_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed steps queue expected
// outputs, a negedge monitor pops and compares them.
module tb_bus_arbiter;

   localparam logic [31:0] D = 32'hC35A3CA5;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        valid;
   logic [7:0]  bus_out;

   typedef struct {
      string      name;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic [7:0] bus;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   bus_arbiter #(.N(4), .DATA_W(8), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data_in (data_in),
      .gnt     (gnt),
      .sel     (sel),
      .valid   (valid),
      .bus_out (bus_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (gnt !== e.gnt || sel !== e.sel ||
             valid !== e.valid || bus_out !== e.bus) begin
            errors++;
            $display("FAIL %s: got gnt=%b sel=%0d valid=%b bus_out=%h, want gnt=%b sel=%0d valid=%b bus_out=%h",
                     e.name, gnt, sel, valid, bus_out,
                     e.gnt, e.sel, e.valid, e.bus);
         end
         checks++;
         if ((gnt & (gnt - 4'd1)) != 4'd0) begin
            errors++;
            $display("FAIL onehot %s: got gnt=%b, want zero or one-hot",
                     e.name, gnt);
         end
      end
   end

   task automatic step(input logic r, input logic [3:0] rq,
                       input logic [31:0] d,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic [7:0] eb,
                       input string nm);
      @(negedge clk);
      #1;
      rst     = r;
      req     = rq;
      data_in = d;
      exp_q.push_back('{name: nm, gnt: eg, sel: es, valid: ev, bus: eb});
   endtask

   initial begin
      rst     = 1'b1;
      req     = '0;
      data_in = D;

      // reset, then a single request
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "reset0");
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "reset1");
      step(0, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "pre_grant");
      step(0, 4'b0001, D, 4'b0001, 0, 1, 8'hA5, "single_grant");
      step(0, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "single_release");

      // all request together, each owner drops after 2 cycles
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "all_reset");
      step(0, 4'b1111, D, 4'b0001, 0, 1, 8'hA5, "all_g0a");
      step(0, 4'b1111, D, 4'b0001, 0, 1, 8'hA5, "all_g0b");
      step(0, 4'b1110, D, 4'b0010, 1, 1, 8'h3C, "all_g1a");
      step(0, 4'b1110, D, 4'b0010, 1, 1, 8'h3C, "all_g1b");
      step(0, 4'b1100, D, 4'b0100, 2, 1, 8'h5A, "all_g2a");
      step(0, 4'b1100, D, 4'b0100, 2, 1, 8'h5A, "all_g2b");
      step(0, 4'b1000, D, 4'b1000, 3, 1, 8'hC3, "all_g3a");
      step(0, 4'b1000, D, 4'b1000, 3, 1, 8'hC3, "all_g3b");
      step(0, 4'b0000, D, 4'b0000, 3, 0, 8'h00, "all_idle");

      // hold limit alternation between requesters 0 and 1
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "hold_reset");
      for (int k = 0; k < 12; k++) begin
         if ((k / 4) % 2 == 0)
            step(0, 4'b0011, D, 4'b0001, 0, 1, 8'hA5, "hold_owner0");
         else
            step(0, 4'b0011, D, 4'b0010, 1, 1, 8'h3C, "hold_owner1");
      end

      // sole requester keeps the bus; bus_out tracks data_in
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "sole_reset");
      for (int k = 0; k < 20; k++) begin
         if (k == 10)
            step(0, 4'b0100, 32'h00770000, 4'b0100, 2, 1, 8'h77, "sole_data");
         else
            step(0, 4'b0100, D, 4'b0100, 2, 1, 8'h5A, "sole_hold");
      end
      step(0, 4'b0000, D, 4'b0000, 2, 0, 8'h00, "sole_release");

      // wrap-around from last=3 and from last=2
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "wrap_reset_a");
      step(0, 4'b1000, D, 4'b1000, 3, 1, 8'hC3, "wrap_own3");
      step(0, 4'b0000, D, 4'b0000, 3, 0, 8'h00, "wrap_idle3");
      step(0, 4'b1001, D, 4'b0001, 0, 1, 8'hA5, "wrap_last3");
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "wrap_reset_b");
      step(0, 4'b0100, D, 4'b0100, 2, 1, 8'h5A, "wrap_own2");
      step(0, 4'b0000, D, 4'b0000, 2, 0, 8'h00, "wrap_idle2");
      step(0, 4'b1001, D, 4'b1000, 3, 1, 8'hC3, "wrap_last2");
      step(0, 4'b0000, D, 4'b0000, 3, 0, 8'h00, "wrap_idle_c");
      step(0, 4'b0100, D, 4'b0100, 2, 1, 8'h5A, "handoff_own2");
      step(0, 4'b1001, D, 4'b1000, 3, 1, 8'hC3, "handoff_to3");

      // reset while requester 2 owns the bus
      step(1, 4'b0000, D, 4'b0000, 0, 0, 8'h00, "mid_reset_a");
      step(0, 4'b1111, D, 4'b0001, 0, 1, 8'hA5, "mid_g0");
      step(0, 4'b1110, D, 4'b0010, 1, 1, 8'h3C, "mid_g1");
      step(0, 4'b1100, D, 4'b0100, 2, 1, 8'h5A, "mid_g2");
      step(0, 4'b1111, D, 4'b0100, 2, 1, 8'h5A, "mid_g2_hold");
      step(1, 4'b1111, D, 4'b0000, 0, 0, 8'h00, "mid_reset");
      step(0, 4'b1111, D, 4'b0001, 0, 1, 8'hA5, "mid_after");

      for (int k = 0; k < 5 && exp_q.size() > 0; k++)
         @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and select controller for a shared N-input data multiplexer in the CPU datapath. It accepts per-requester requests, issues one-hot registered grants with fair rotation and a bounded hold time, and drives the select index of the shared mux. It is the sequencing layer above the 2:1 and N:1 mux primitives, so that several masters such as the fetch unit, load/store unit and DMA can share one bus.

## Interface
- N, default 4: number of requesters; 2 to 8.
- DATA_W, default 8: width of each requester's data word.
- MAX_HOLD, default 4: maximum consecutive grant cycles for one owner while another requester is pending; must be at least 1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i is high while requester i wants or holds the bus.
- data_in  input  N*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  N  one-hot grant (registered); all zero when idle.
- sel  output  clog2(N)  index of the current owner (registered).
- valid  output  1  high when a grant is active; equals the OR of gnt.
- bus_out  output  DATA_W  data_in of the owner selected by sel when valid is high; 0 when valid is low (combinational from the registered sel/valid).

## Operation
- State machine with two states:
  - IDLE: no owner; gnt=0.
  - GRANT: one owner.
- Internal registers:
  - last: index of the most recent owner.
  - hold_cnt: grant-cycle counter, width clog2(MAX_HOLD+1).
- Arbitration search: scan (last+1) mod N upward with wrap-around, and pick the first i with req[i]=1.
- IDLE:
  - If any req is high, pick the winner by the search and go to GRANT.
  - Load gnt, sel, last and valid; set hold_cnt=1.
- GRANT with owner o:
  - **Release.** If req[o]=0 and another requester is pending, pick a new winner by the search starting at o+1 in the same edge. There is no idle bubble. Set hold_cnt=1.
  - **Release, nobody waiting.** If req[o]=0 and no other req is high, go to IDLE; gnt=0, valid=0.
  - **Hold limit.** If req[o]=1, hold_cnt==MAX_HOLD and any other req is high, force rotation to the next winner by the search. The preempted owner keeps its request and re-competes normally.
  - **Continue.** If req[o]=1 and no forced rotation applies, keep the owner. Increment hold_cnt, saturating at MAX_HOLD.
  - **Sole requester.** If only the owner requests, it keeps the grant indefinitely and the counter stays saturated.
- The preemption check ignores req[o]. The search can return o only when o is the sole requester.
- gnt is always zero or one-hot. sel always equals the index of the set gnt bit. When valid=0, sel holds the last owner.
- bus_out = data_in[sel*DATA_W +: DATA_W] when valid=1, else 0.

## Timing
- Reset values, applied on the edge where rst=1:
  - gnt=0, sel=0, valid=0, hold_cnt=0, state IDLE.
  - last=N-1, so requester 0 has first priority after reset.
- rst has priority over every other event. Reset mid-grant clears the grant on the following edge without completing the rotation.
- Grant latency: req[i] rising before edge t gives gnt[i] visible after edge t. That is one cycle from an idle bus.
- Release latency: the owner drops req before edge t; gnt drops, or moves to the next owner, after edge t. The owner must tolerate one trailing grant cycle after deasserting req.
- Maximum continuous ownership under contention is exactly MAX_HOLD cycles.
- Worst-case wait for a continuously requesting requester is (N-1)*MAX_HOLD cycles.
- Simultaneous requests are resolved purely by rotation order from last+1.
- bus_out follows data_in combinationally, with no added latency, while sel/valid are stable.

## Test plan
- **Reset, then single request.** rst for 2 cycles, then req=0001 with data_in word0=8'hA5. Required: gnt=0001, sel=0, valid=1 and bus_out=8'hA5 after one edge. Before that edge, bus_out=0.
- **All request together.** req=1111 from reset, each owner drops req after 2 grant cycles. Required grant order 0,1,2,3 with back-to-back handoff and no cycle with valid=0. Required gnt one-hot every cycle.
- **Hold limit.** MAX_HOLD=4, req0 and req1 held high continuously. Required: gnt=0001 for exactly 4 cycles, then 0010 for 4 cycles, then 0001 again, alternating.
- **Sole requester.** req=0100 held high for 20 cycles. Required: gnt=0100 for all 20 cycles with no preemption. req then drops to 0000; required gnt=0000, valid=0 one edge later, with sel still 2.
- **Wrap-around.** last=3 (owner 3 just released) with req=1001. Required: next grant goes to 0. With last=2 and req=1001, required: next grant goes to 3.
- **Reset mid-grant.** Owner 2 granted with req=1111, then rst for 1 cycle. Required: gnt=0 and valid=0 after that edge. The first grant after reset goes to requester 0.
